// File: rtl/gearbox_pkg.sv
// Shared types for the width gearbox.
package gearbox_pkg;

  // FILL: no packet end pending; DRAIN: last input seen, residual bits still to emit
  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } gb_state_t;

endpackage

// File: rtl/width_gearbox.sv
// Packs an IN_W-bit input stream into OUT_W-bit output words, LSB first,
// with packet framing; the final word of a packet is zero-padded.
module width_gearbox
  import gearbox_pkg::*;
#(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_W-1:0]              din,
  input  logic                         din_vld,
  input  logic                         din_last,
  output logic                         din_rdy,
  output logic [OUT_W-1:0]             dout,
  output logic                         dout_vld,
  output logic                         dout_last,
  output logic [$clog2(OUT_W+1)-1:0]   dout_nbits,
  input  logic                         dout_rdy
);

  localparam int unsigned BUF_W = IN_W + OUT_W;
  localparam int unsigned CNT_W = $clog2(BUF_W + 1);
  localparam int unsigned NB_W  = $clog2(OUT_W + 1);

  gb_state_t          state_q, state_d;
  logic [BUF_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   popped;
  logic [CNT_W-1:0]   wr_pos;
  logic               full_word;
  logic               push;
  logic               pop;

  // Handshake and output view, all derived from registered state only
  assign full_word  = (cnt_q >= CNT_W'(OUT_W));
  assign dout       = acc_q[OUT_W-1:0];
  assign dout_nbits = full_word ? NB_W'(OUT_W) : NB_W'(cnt_q);
  assign dout_vld   = full_word || ((state_q == DRAIN) && (cnt_q != '0));
  assign dout_last  = (state_q == DRAIN) && (cnt_q != '0) && (cnt_q <= CNT_W'(OUT_W));
  assign din_rdy    = (state_q == FILL) && ((CNT_W'(BUF_W) - cnt_q) >= CNT_W'(IN_W));
  assign push       = din_vld && din_rdy;
  assign pop        = dout_vld && dout_rdy;

  // Accumulator update: drop the popped word first, then append din above the survivors
  always_comb begin
    acc_d  = acc_q;
    popped = '0;
    if (pop) begin
      popped = full_word ? CNT_W'(OUT_W) : cnt_q;
      acc_d  = acc_q >> OUT_W;
    end
    wr_pos = cnt_q - popped;
    if (push) begin
      acc_d = acc_d | (BUF_W'(din) << wr_pos);
    end
    cnt_d = wr_pos + (push ? CNT_W'(IN_W) : CNT_W'(0));
  end

  // Packet framing: enter DRAIN on accepted last input, leave once the last word is popped
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (push && din_last) state_d = DRAIN;
      DRAIN:   if (pop && dout_last) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator and bit-count registers; reset discards any partial packet
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
